// File: rtl/spm_pkg.sv
// Shared types and helpers for the RISC_SPM program loader.
package spm_pkg;

    localparam int unsigned WORD_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    function automatic logic [WORD_SIZE-1:0] csum_add(input logic [WORD_SIZE-1:0] a,
                                                       input logic [WORD_SIZE-1:0] b);
        return WORD_SIZE'(a + b);
    endfunction

endpackage

// File: rtl/spm_loader_timer.sv
// Inter-byte idle timer: counts enabled cycles and flags the last one before TIMEOUT_CYCLES.
module spm_loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Fires in the cycle that would be the TIMEOUT_CYCLES-th idle one, so ERROR follows on the edge.
    assign timeout_c = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spm_program_loader.sv
// Boot loader: receives ADDR/LEN/DATA[/CSUM] frames and writes them into program memory.
// Optional LOADER_CHECKSUM_EN adds the trailing checksum byte and its verification.
module spm_program_loader
    import spm_pkg::*;
#(
    parameter int unsigned word_size      = WORD_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_write,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_data,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL = CSUM;
`else
    localparam loader_state_t TAIL = DONE;
`endif

    loader_state_t        state, state_next;
    logic [word_size-1:0] addr_cnt;
    logic [word_size-1:0] len_cnt;
    logic                 xfer;
    logic                 start_ok;
    logic                 timeout_c;

    assign xfer     = in_valid && in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

`ifdef LOADER_CHECKSUM_EN
    logic [word_size-1:0] csum;
    logic                 csum_good;
    assign csum_good = (csum_add(csum, in_data) == '0);
`endif

    spm_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok || xfer || !busy),
        .enable   (busy && !xfer),
        .timeout_c(timeout_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a transfer always beats a timeout in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_next = ADDR;
            ADDR: begin
                if (xfer)           state_next = LEN;
                else if (timeout_c) state_next = ERROR;
            end
            LEN: begin
                if (xfer)           state_next = (in_data == '0) ? TAIL : DATA;
                else if (timeout_c) state_next = ERROR;
            end
            DATA: begin
                if (xfer) begin
                    if (len_cnt == word_size'(1)) state_next = TAIL;
                end else if (timeout_c) begin
                    state_next = ERROR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer)           state_next = csum_good ? DONE : ERROR;
                else if (timeout_c) state_next = ERROR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State-decoded status outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            ADDR, LEN, DATA, CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address/length counters, registered memory write port, CPU reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_rst   <= 1'b1;
            addr_cnt  <= '0;
            len_cnt   <= '0;
        end else begin
            mem_write <= 1'b0;
            cpu_rst   <= (state_next != DONE);
            if (xfer) begin
                case (state)
                    ADDR: addr_cnt <= in_data;
                    LEN:  len_cnt  <= in_data;
                    DATA: begin
                        mem_write <= 1'b1;
                        mem_addr  <= addr_cnt;
                        mem_data  <= in_data;
                        addr_cnt  <= addr_cnt + word_size'(1);
                        len_cnt   <= len_cnt - word_size'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running modular sum over every accepted byte of the frame
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum_add(csum, in_data);
        end
    end
`endif

endmodule

// File: tb/tb_spm_program_loader.sv
// Directed self-checking bench for spm_program_loader (checksum build selected by LOADER_CHECKSUM_EN).
module tb_spm_program_loader;

    localparam int unsigned TO = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       error;

    int checks      = 0;
    int errors      = 0;
    int write_count = 0;
    int wc0;

    spm_program_loader #(
        .word_size     (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_write === 1'b1) write_count++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        chk("in_ready_before_send", 16'(in_ready), 16'h1);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 16'(busy), 16'h1);
        chk("cpu_rst_after_start", 16'(cpu_rst), 16'h1);
    endtask

    task automatic chk_write(input string tag, input logic [7:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 16'(mem_write), 16'h1);
        chk({tag, "_addr"}, 16'(mem_addr), 16'(a));
        chk({tag, "_data"}, 16'(mem_data), 16'(d));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 16'(in_ready), 16'h0);
        chk({tag, "_mem_write"}, 16'(mem_write), 16'h0);
        chk({tag, "_mem_addr"}, 16'(mem_addr), 16'h0);
        chk({tag, "_mem_data"}, 16'(mem_data), 16'h0);
        chk({tag, "_cpu_rst"}, 16'(cpu_rst), 16'h1);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
        chk({tag, "_done"}, 16'(done), 16'h0);
        chk({tag, "_error"}, 16'(error), 16'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step(); step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // T1: good frame 10,03,AA,BB,CC[,BC]
        do_start();
        send(8'h10);
        chk("t1_no_write_addr", 16'(mem_write), 16'h0);
        send(8'h03);
        chk("t1_no_write_len", 16'(mem_write), 16'h0);
        send(8'hAA); chk_write("t1_w0", 8'h10, 8'hAA);
        send(8'hBB); chk_write("t1_w1", 8'h11, 8'hBB);
        send(8'hCC); chk_write("t1_w2", 8'h12, 8'hCC);
`ifdef LOADER_CHECKSUM_EN
        chk("t1_not_done_before_csum", 16'(done), 16'h0);
        chk("t1_cpu_rst_before_csum", 16'(cpu_rst), 16'h1);
        send(8'hBC);
        chk("t1_no_write_csum", 16'(mem_write), 16'h0);
`endif
        chk("t1_done", 16'(done), 16'h1);
        chk("t1_cpu_rst_low", 16'(cpu_rst), 16'h0);
        chk("t1_busy_low", 16'(busy), 16'h0);
        step();
        chk("t1_write_ends", 16'(mem_write), 16'h0);
        chk("t1_done_holds", 16'(done), 16'h1);

`ifdef LOADER_CHECKSUM_EN
        // T2: bad checksum
        wc0 = write_count;
        do_start();
        send(8'h10); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hBD);
        chk("t2_error", 16'(error), 16'h1);
        chk("t2_done_low", 16'(done), 16'h0);
        chk("t2_cpu_rst_high", 16'(cpu_rst), 16'h1);
        chk("t2_three_writes", 16'(write_count - wc0), 16'd3);
`endif

        // T3: start and byte together outside a frame; start wins, byte dropped. Then wrap.
        start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        step();
        start = 1'b0; in_valid = 1'b0;
        chk("t3_busy_after_start", 16'(busy), 16'h1);
        chk("t3_cpu_rst_after_start", 16'(cpu_rst), 16'h1);
        send(8'hFE);
        send(8'h03);
        send(8'h01); chk_write("t3_w0", 8'hFE, 8'h01);
        send(8'h02); chk_write("t3_w1", 8'hFF, 8'h02);
        send(8'h03); chk_write("t3_w2", 8'h00, 8'h03);
`ifdef LOADER_CHECKSUM_EN
        send(8'hF9);
`endif
        chk("t3_done", 16'(done), 16'h1);

        // T4: timeout in ADDR
        do_start();
        repeat (TO - 1) step();
        chk("t4_no_error_before_timeout", 16'(error), 16'h0);
        chk("t4_busy_before_timeout", 16'(busy), 16'h1);
        step();
        chk("t4_error_at_timeout", 16'(error), 16'h1);
        chk("t4_in_ready_low", 16'(in_ready), 16'h0);
        chk("t4_cpu_rst_high", 16'(cpu_rst), 16'h1);
        step();
        chk("t4_in_ready_stays_low", 16'(in_ready), 16'h0);

        // T5: streaming data, start ignored while busy, then reset mid-DATA
        do_start();
        send(8'h40);
        send(8'h08);
        in_valid = 1'b1;
        in_data = 8'h00; step(); chk_write("t5_w0", 8'h40, 8'h00);
        in_data = 8'h11; step(); chk_write("t5_w1", 8'h41, 8'h11);
        start = 1'b1;
        in_data = 8'h22; step(); chk_write("t5_w2", 8'h42, 8'h22);
        start = 1'b0;
        chk("t5_start_ignored", 16'(busy), 16'h1);
        in_data = 8'h33; step(); chk_write("t5_w3", 8'h43, 8'h33);
        rst = 1'b1;
        in_data = 8'h44; step();
        rst = 1'b0; in_valid = 1'b0;
        chk_reset_outputs("t5_rst");
        wc0 = write_count;
        repeat (3) step();
        chk("t5_no_writes_after_rst", 16'(write_count - wc0), 16'd0);
        chk("t5_idle_busy", 16'(busy), 16'h0);

        // T6: empty frame 20,00
        wc0 = write_count;
        do_start();
        send(8'h20);
        send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        chk("t6_in_csum", 16'(busy), 16'h1);
        send(8'hE0);
`endif
        chk("t6_done", 16'(done), 16'h1);
        chk("t6_cpu_rst_low", 16'(cpu_rst), 16'h0);
        step();
        chk("t6_zero_writes", 16'(write_count - wc0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
